// File: rtl/crc8_rx_arq_ctrl.sv
// crc8_rx_arq_ctrl: stop-and-wait receive controller for CRC-8 frames.
// Frames are checked one byte per cycle, MSB byte first. The CRC uses poly 0x07,
// init 0x00, no reflection and no final XOR, and a good frame leaves a zero residue.
// Good payloads are handed on over valid/ready. Bad frames raise nak, with bounded
// retries and a timeout that reissues nak.
// Optional feature: define CRC_RX_STATS_EN to add saturating stat_good, stat_bad
// and stat_drop counters.
module crc8_rx_arq_ctrl #(
  parameter int BW        = 40,
  parameter int CRC_BW    = 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BW+CRC_BW-1:0] in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BW-1:0]        out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ack,
  output logic                 nak,
  output logic                 drop
`ifdef CRC_RX_STATS_EN
  ,
  output logic [15:0]          stat_good,
  output logic [15:0]          stat_bad,
  output logic [15:0]          stat_drop
`endif
);

  localparam int FW = BW + CRC_BW;
  localparam int NB = FW / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DELIVER,
    S_NAK,
    S_WAIT
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [BW-1:0]  payload;
  logic [FW-1:0]  shreg;
  logic [7:0]     crc;
  logic [7:0]     crc_next;
  logic [IW-1:0]  idx;
  logic [RW-1:0]  retry;
  logic [TW-1:0]  tmo;
  logic           accept;
  logic           last_byte;
  logic           retry_exhausted;

  // One CRC-8 (poly 0x07) step over a whole byte, MSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign accept          = in_valid && in_ready;
  assign crc_next        = crc8_byte(crc, shreg[FW-1 -: 8]);
  assign last_byte       = (idx == IW'(NB - 1));
  assign retry_exhausted = (retry == RW'(MAX_RETRY));
  assign out             = payload;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a handshake in WAIT takes priority over the timeout
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (in_valid) state_next = S_CHECK;
      S_CHECK:   if (last_byte) state_next = (crc_next == 8'h00) ? S_DELIVER : S_NAK;
      S_DELIVER: if (out_ready) state_next = S_IDLE;
      S_NAK:     state_next = retry_exhausted ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (in_valid)                     state_next = S_CHECK;
        else if (tmo == TW'(TIMEOUT - 1)) state_next = S_NAK;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Moore/Mealy outputs decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    ack       = 1'b0;
    nak       = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE:    in_ready = 1'b1;
      S_WAIT:    in_ready = 1'b1;
      S_DELIVER: begin
        out_valid = 1'b1;
        ack       = out_ready;
      end
      S_NAK: begin
        nak  = !retry_exhausted;
        drop = retry_exhausted;
      end
      default: ;
    endcase
  end

  // Frame capture and byte-serial CRC; the shift register presents the next byte at its top
  always_ff @(posedge clk) begin
    if (!rstn) begin
      payload <= '0;
      shreg   <= '0;
      crc     <= '0;
      idx     <= '0;
    end else if (accept) begin
      payload <= in[FW-1:CRC_BW];
      shreg   <= in;
      crc     <= '0;
      idx     <= '0;
    end else if (state == S_CHECK) begin
      crc     <= crc_next;
      shreg   <= shreg << 8;
      idx     <= idx + IW'(1);
    end
  end

  // Retry count survives WAIT, cleared on delivery or when the frame is dropped
  always_ff @(posedge clk) begin
    if (!rstn) begin
      retry <= '0;
    end else if (state == S_NAK) begin
      retry <= retry_exhausted ? '0 : retry + RW'(1);
    end else if (ack) begin
      retry <= '0;
    end
  end

  // Timeout counter runs only while waiting for a retransmission
  always_ff @(posedge clk) begin
    if (!rstn)                tmo <= '0;
    else if (state == S_WAIT) tmo <= tmo + TW'(1);
    else                      tmo <= '0;
  end

`ifdef CRC_RX_STATS_EN
  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_good <= '0;
      stat_bad  <= '0;
      stat_drop <= '0;
    end else begin
      if (ack && stat_good != 16'hFFFF) stat_good <= stat_good + 16'd1;
      if (state == S_CHECK && state_next == S_NAK && stat_bad != 16'hFFFF)
        stat_bad <= stat_bad + 16'd1;
      if (drop && stat_drop != 16'hFFFF) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_rx_arq_ctrl.sv
// tb_crc8_rx_arq_ctrl: scoreboard bench for crc8_rx_arq_ctrl with directed frames.
// Expected ack/nak/drop events are queued by the stimulus and consumed by a monitor.
// Honours CRC_RX_STATS_EN for the optional statistics ports.
module tb_crc8_rx_arq_ctrl;

  localparam int K_ACK  = 0;
  localparam int K_NAK  = 1;
  localparam int K_DROP = 2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [39:0] payload;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [47:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ack;
  logic        nak;
  logic        drop;
`ifdef CRC_RX_STATS_EN
  logic [15:0] stat_good;
  logic [15:0] stat_bad;
  logic [15:0] stat_drop;
`endif

  int   total_checks = 0;
  int   passed_checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  crc8_rx_arq_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .in        (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack),
    .nak       (nak),
    .drop      (drop)
`ifdef CRC_RX_STATS_EN
    ,
    .stat_good (stat_good),
    .stat_bad  (stat_bad),
    .stat_drop (stat_drop)
`endif
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Free-running edge counter used for latency and spacing measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  task automatic push_exp(input int kind, input logic [39:0] payload);
    exp_t e;
    e.kind    = kind[1:0];
    e.payload = payload;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a frame and hold in_valid until the handshake edge; returns just after that edge
  task automatic apply_stimulus(input logic [47:0] frame, output int accept_cyc);
    int n;
    n = 0;
    in_data  = frame;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    step();
    in_valid   = 1'b0;
    accept_cyc = cyc;
    if (n >= 200) check_output("accept_timeout", 64'(n), 64'd0);
  endtask

  // Cycles from acceptance until out_valid, nak or drop is seen
  task automatic wait_outcome(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(out_valid || nak || drop) && n < 100);
  endtask

  // Monitor: every handshake or pulse must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    logic hs;
    exp_t e;
    int   kind;
    if (rstn === 1'b1) begin
      hs = out_valid && out_ready;
      if (hs || ack || nak || drop) begin
        check_output("ack_eq_handshake", 64'(ack), 64'(hs));
        check_output("pulse_exclusive", 64'($countones({ack, nak, drop}) <= 1), 64'd1);
        kind = hs ? K_ACK : (nak ? K_NAK : K_DROP);
        if (sb.size() == 0) begin
          check_output("unexpected_event", 64'(kind), 64'hFF);
        end else begin
          e = sb.pop_front();
          check_output("event_kind", 64'(kind), 64'(e.kind));
          if (kind == K_ACK) check_output("payload", 64'(out_data), 64'(e.payload));
        end
      end
    end
  end

  initial begin : stim
    int n;
    int acc_a;
    int acc_b;
    int drop_cyc;
    int nak_cyc[$];

    rstn      = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset held for two edges
    step();
    step();
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out", 64'(out_data), 64'd0);
    check_output("rst_pulses", 64'({ack, nak, drop}), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    rstn = 1'b1;
    step();
    check_output("idle_in_ready", 64'(in_ready), 64'd1);

    // Good frame, consumer ready
    out_ready = 1'b1;
    push_exp(K_ACK, 40'h0000000001);
    apply_stimulus(48'h0000000001_07, acc_a);
    check_output("check_in_ready", 64'(in_ready), 64'd0);
    wait_outcome(n);
    check_output("good_latency", 64'(n), 64'd6);
    step();
    check_output("back_idle", 64'({in_ready, out_valid}), 64'b10);

    // Bad frame, then retransmission during WAIT
    push_exp(K_NAK, 40'h0);
    apply_stimulus(48'h0000000001_00, acc_a);
    wait_outcome(n);
    check_output("nak_latency", 64'(n), 64'd6);
    check_output("nak_state_in_ready", 64'(in_ready), 64'd0);
    step();
    check_output("wait_in_ready", 64'(in_ready), 64'd1);
    push_exp(K_ACK, 40'h0000000001);
    apply_stimulus(48'h0000000001_07, acc_a);
    wait_outcome(n);
    check_output("resend_latency", 64'(n), 64'd6);
    step();

    // Bad frame with no retransmission: three naks 65 cycles apart, then drop
    push_exp(K_NAK, 40'h0);
    push_exp(K_NAK, 40'h0);
    push_exp(K_NAK, 40'h0);
    push_exp(K_DROP, 40'h0);
    apply_stimulus(48'h0000000001_00, acc_a);
    drop_cyc = -1;
    n = 0;
    while (drop_cyc < 0 && n < 400) begin
      step();
      n++;
      if (nak) nak_cyc.push_back(cyc);
      if (drop) drop_cyc = cyc;
    end
    check_output("nak_count", 64'(nak_cyc.size()), 64'd3);
    check_output("drop_seen", 64'(drop_cyc >= 0), 64'd1);
    if (nak_cyc.size() == 3) begin
      check_output("first_nak_latency", 64'(nak_cyc[0] - acc_a), 64'd6);
      check_output("nak_gap_1", 64'(nak_cyc[1] - nak_cyc[0]), 64'd65);
      check_output("nak_gap_2", 64'(nak_cyc[2] - nak_cyc[1]), 64'd65);
      check_output("drop_gap", 64'(drop_cyc - nak_cyc[2]), 64'd65);
    end
    step();
    check_output("after_drop_idle", 64'(in_ready), 64'd1);

    // Consumer stalls for 10 cycles; payload must hold
    out_ready = 1'b0;
    push_exp(K_ACK, 40'h0000000100);
    apply_stimulus(48'h0000000100_15, acc_a);
    wait_outcome(n);
    check_output("stall_latency", 64'(n), 64'd6);
    for (int i = 0; i < 10; i++) begin
      check_output("stall_hold", 64'({out_valid, in_ready, out_data}), {23'd0, 1'b1, 1'b0, 40'h0000000100});
      if (i < 9) step();
    end
    out_ready = 1'b1;
    step();
    check_output("stall_release_idle", 64'({in_ready, out_valid}), 64'b10);

    // Back-to-back frames: one frame every NB+2 cycles
    push_exp(K_ACK, 40'h00000000FF);
    push_exp(K_ACK, 40'h0000000080);
    apply_stimulus(48'h00000000FF_F3, acc_a);
    apply_stimulus(48'h0000000080_89, acc_b);
    check_output("throughput", 64'(acc_b - acc_a), 64'd8);
    wait_outcome(n);
    step();

`ifdef CRC_RX_STATS_EN
    check_output("stat_good_pre", 64'(stat_good), 64'd5);
    check_output("stat_bad_pre", 64'(stat_bad), 64'd2);
    check_output("stat_drop_pre", 64'(stat_drop), 64'd1);
`endif

    // Reset mid-CHECK on a bad frame: nothing must be reported
    apply_stimulus(48'h0000000001_00, acc_a);
    step();
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check_output("midrst_state", 64'({in_ready, out_valid, ack, nak, drop}), 64'b10000);
    for (int i = 0; i < 8; i++) step();
    push_exp(K_ACK, 40'h0);
    apply_stimulus(48'h0000000000_00, acc_a);
    wait_outcome(n);
    check_output("post_rst_latency", 64'(n), 64'd6);
    step();
`ifdef CRC_RX_STATS_EN
    check_output("stat_good", 64'(stat_good), 64'd1);
    check_output("stat_bad", 64'(stat_bad), 64'd0);
    check_output("stat_drop", 64'(stat_drop), 64'd0);
`endif

    for (int i = 0; i < 4; i++) step();
    check_output("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
